// File: rtl/audio_frame_buffer.sv
// Pre-emphasised audio capture into a 2*FRAME_LEN circular buffer, emitting overlapping
// FRAME_LEN-sample frames every HOP samples on a valid/ready stream; counts dropped frames.
module audio_frame_buffer #(
  parameter int DATA_W    = 16,
  parameter int FRAME_LEN = 256,
  parameter int HOP       = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              overrun,
  output logic [7:0]        frames_dropped
);

  localparam int DEPTH = 2 * FRAME_LEN;
  localparam int AW    = $clog2(DEPTH);
  localparam int IW    = $clog2(FRAME_LEN);
  localparam int CW    = $clog2(FRAME_LEN + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_LEN - 1);
  localparam logic signed [DATA_W+1:0] Y_MAX = {3'b000, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W+1:0] Y_MIN = {3'b111, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, LOAD, STREAM} state_t;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] x_prev;
  logic [AW-1:0]     wr_ptr;
  logic [CW-1:0]     fill_cnt;
  logic [CW-1:0]     hop_cnt;
  state_t            state;
  logic [AW-1:0]     base;
  logic [IW-1:0]     rd_idx;
  logic              pending;
  logic [AW-1:0]     pend_addr;

  logic signed [DATA_W+1:0] x_ext, xp_ext, y_wide;
  logic [DATA_W-1:0] y_sat;
  logic accept, full, trigger, busy, xfer, last_xfer, hit_active;
  logic [AW-1:0] new_start, wr_off, rd_addr;

  assign x_ext  = {{2{sample_in[DATA_W-1]}}, sample_in};
  assign xp_ext = {{2{x_prev[DATA_W-1]}}, x_prev};
  assign y_wide = x_ext - xp_ext + (xp_ext >>> 5);
  assign y_sat  = (y_wide > Y_MAX) ? Y_MAX[DATA_W-1:0] :
                  (y_wide < Y_MIN) ? Y_MIN[DATA_W-1:0] : y_wide[DATA_W-1:0];

  assign accept    = enable & sample_valid;
  assign full      = (fill_cnt == CW'(FRAME_LEN));
  assign trigger   = accept & ((!full && fill_cnt == CW'(FRAME_LEN - 1)) ||
                               (full && hop_cnt == CW'(HOP - 1)));
  // Start of the frame ending with the sample being written this cycle.
  assign new_start = wr_ptr + AW'(1) - AW'(FRAME_LEN);
  assign busy      = (state != IDLE);
  assign xfer      = (state == STREAM) & out_valid & out_ready;
  assign last_xfer = xfer & (rd_idx == LAST_IDX);
  assign wr_off    = wr_ptr - base;
  assign hit_active = accept & busy & !wr_off[AW-1] & (wr_off[IW-1:0] >= rd_idx);
  // LOAD fetches the current index; STREAM prefetches the next one on a transfer.
  assign rd_addr   = base + ((state == LOAD) ? {1'b0, rd_idx} : ({1'b0, rd_idx} + AW'(1)));

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= y_sat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      fill_cnt <= '0;
      hop_cnt  <= '0;
      x_prev   <= '0;
    end else if (!enable) begin
      wr_ptr   <= '0;
      fill_cnt <= '0;
      hop_cnt  <= '0;
      x_prev   <= '0;
    end else if (accept) begin
      wr_ptr <= wr_ptr + AW'(1);
      x_prev <= sample_in;
      if (!full) fill_cnt <= fill_cnt + CW'(1);
      else       hop_cnt  <= (hop_cnt == CW'(HOP - 1)) ? '0 : hop_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      base           <= '0;
      rd_idx         <= '0;
      pending        <= 1'b0;
      pend_addr      <= '0;
      out_data       <= '0;
      out_valid      <= 1'b0;
      out_last       <= 1'b0;
      overrun        <= 1'b0;
      frames_dropped <= '0;
    end else if (!enable) begin
      state          <= IDLE;
      rd_idx         <= '0;
      pending        <= 1'b0;
      out_valid      <= 1'b0;
      out_last       <= 1'b0;
      overrun        <= 1'b0;
      frames_dropped <= '0;
    end else begin
      if (hit_active) overrun <= 1'b1;
      case (state)
        IDLE: begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          rd_idx    <= '0;
          if (trigger) begin
            base  <= new_start;
            state <= LOAD;
          end else if (pending) begin
            base    <= pend_addr;
            pending <= 1'b0;
            state   <= LOAD;
          end
        end
        LOAD: begin
          out_data  <= mem[rd_addr];
          out_valid <= 1'b1;
          out_last  <= (rd_idx == LAST_IDX);
          state     <= STREAM;
        end
        STREAM: begin
          if (xfer) begin
            if (rd_idx == LAST_IDX) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              rd_idx    <= '0;
              // A trigger coinciding with the final beat never counts as a drop.
              if (pending) begin
                base      <= pend_addr;
                pending   <= trigger;
                pend_addr <= new_start;
                state     <= LOAD;
              end else if (trigger) begin
                base  <= new_start;
                state <= LOAD;
              end else begin
                state <= IDLE;
              end
            end else begin
              rd_idx   <= rd_idx + IW'(1);
              out_data <= mem[rd_addr];
              out_last <= (rd_idx + IW'(1) == LAST_IDX);
            end
          end
        end
        default: state <= IDLE;
      endcase
      if (trigger && busy && !last_xfer) begin
        pending   <= 1'b1;
        pend_addr <= new_start;
        if (pending && frames_dropped != 8'hFF) frames_dropped <= frames_dropped + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_audio_frame_buffer.sv
// Directed + randomized bench for audio_frame_buffer (FRAME_LEN=8, HOP=4) with a
// sample-history reference model that predicts each frame's contents.
module tb_audio_frame_buffer;
  localparam int FL  = 8;
  localparam int HOP = 4;

  logic        clk = 1'b0;
  logic        rst_n, enable, sample_valid, out_ready;
  logic [15:0] sample_in, out_data;
  logic        out_valid, out_last, overrun;
  logic [7:0]  frames_dropped;

  audio_frame_buffer #(.DATA_W(16), .FRAME_LEN(FL), .HOP(HOP)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .sample_in(sample_in),
    .sample_valid(sample_valid), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .overrun(overrun),
    .frames_dropped(frames_dropped)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [16:0] exp_q[$];
  int ys[$];
  int pend_exp[$];
  int xp, n, xfers, lasts, fpos, x0, l0;
  logic chk_data;
  logic [15:0] got[FL];
  logic stalled_prev;
  logic [15:0] held_data;
  logic held_last;
  logic [15:0] first_x;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pre(input int x, input int p);
    int y;
    y = x - p + (p >>> 5);
    if (y > 32767) y = 32767;
    if (y < -32768) y = -32768;
    return y;
  endfunction

  task automatic model_reset();
    ys.delete();
    exp_q.delete();
    xp = 0;
    n = 0;
    fpos = 0;
    stalled_prev = 1'b0;
  endtask

  // Each trigger yields the last FL filtered samples, oldest first.
  task automatic model_accept(input logic [15:0] x);
    int xs;
    xs = int'($signed(x));
    ys.push_back(pre(xs, xp));
    xp = xs;
    if (ys.size() > FL) void'(ys.pop_front());
    n++;
    if (n == FL || (n > FL && (n - FL) % HOP == 0))
      for (int k = 0; k < FL; k++) exp_q.push_back({k == FL - 1, 16'(ys[k])});
  endtask

  task automatic cyc(input logic en, input logic sv, input logic [15:0] x, input logic rdy);
    logic [16:0] e;
    @(posedge clk);
    #1;
    enable = en; sample_valid = sv; sample_in = x; out_ready = rdy;
    @(negedge clk);
    if (stalled_prev && out_valid) begin
      chk("stall_data", 32'(out_data), 32'(held_data));
      chk("stall_last", 32'(out_last), 32'(held_last));
    end
    stalled_prev = out_valid && !out_ready;
    held_data = out_data;
    held_last = out_last;
    if (out_valid && out_ready) begin
      xfers++;
      got[fpos] = out_data;
      fpos = out_last ? 0 : (fpos + 1) % FL;
      if (out_last) lasts++;
      if (chk_data) begin
        chk("xfer_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("data", 32'(out_data), 32'(e[15:0]));
          chk("last", 32'(out_last), 32'(e[16]));
        end
      end
    end
    if (en && sv) model_accept(x);
  endtask

  task automatic flush();
    cyc(1'b0, 1'b0, 16'h0, 1'b0);
    model_reset();
  endtask

  initial begin
    rst_n = 1'b1; enable = 1'b0; sample_valid = 1'b0; sample_in = '0; out_ready = 1'b0;
    xfers = 0; lasts = 0; chk_data = 1'b1;
    model_reset();
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_dropped", 32'(frames_dropped), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Saturation in both directions.
    cyc(1, 1, 16'h7fff, 1); cyc(1, 1, 16'h8000, 1); cyc(1, 1, 16'h7fff, 1);
    cyc(1, 1, 16'd100, 1);  cyc(1, 1, 16'hff38, 1); cyc(1, 1, 16'd5, 1);
    cyc(1, 1, 16'd0, 1);    cyc(1, 1, 16'd7, 1);
    repeat (14) cyc(1, 0, 16'h0, 1);
    chk("t3_drained", 32'(exp_q.size()), 32'd0);
    chk("t3_y0", 32'(got[0]), 32'h7fff);
    chk("t3_sat_neg", 32'(got[1]), 32'h8000);
    chk("t3_sat_pos", 32'(got[2]), 32'h7fff);
    chk("t3_lasts", 32'(lasts), 32'd1);

    // Constant input, latency, and a trigger landing while streaming.
    flush();
    l0 = lasts;
    for (int i = 1; i <= 12; i++) begin
      cyc(1, 1, 16'd1000, 1);
      if (i == 9)  chk("t2_lat_load", 32'(out_valid), 32'd0);
      if (i == 10) chk("t2_lat_stream", 32'(out_valid), 32'd1);
    end
    repeat (25) cyc(1, 0, 16'h0, 1);
    chk("t2_drained", 32'(exp_q.size()), 32'd0);
    chk("t2_frames", 32'(lasts - l0), 32'd2);
    chk("t2_f2_word7", 32'(got[7]), 32'd31);
    chk("t2_overrun", 32'(overrun), 32'd0);
    chk("t2_dropped", 32'(frames_dropped), 32'd0);

    // Consumer stalled: drops, overrun, then pending frame.
    flush();
    chk_data = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      cyc(1, 1, 16'($urandom), 0);
      if (i == 17) begin
        chk("t4_no_overrun_yet", 32'(overrun), 32'd0);
        chk("t4_drop1", 32'(frames_dropped), 32'd1);
      end
      if (i == 18) chk("t4_overrun_set", 32'(overrun), 32'd1);
    end
    cyc(1, 0, 16'h0, 0);
    chk("t4_dropped", 32'(frames_dropped), 32'd2);
    chk("t4_overrun", 32'(overrun), 32'd1);
    pend_exp = ys;
    exp_q.delete();
    x0 = xfers; l0 = lasts;
    for (int c = 0; c < 30 && lasts == l0; c++) cyc(1, 0, 16'h0, 1);
    chk("t4_frame1_len", 32'(xfers - x0), 32'd8);
    chk("t4_frame1_end", 32'(lasts - l0), 32'd1);
    for (int k = 0; k < FL; k++) exp_q.push_back({k == FL - 1, 16'(pend_exp[k])});
    chk_data = 1'b1;
    x0 = xfers;
    for (int c = 0; c < 30 && xfers - x0 < 3; c++) cyc(1, 0, 16'h0, 1);
    chk("t4_pend_started", 32'(xfers - x0), 32'd3);

    // Asynchronous reset in the middle of a frame.
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_valid", 32'(out_valid), 32'd0);
    chk("t1_overrun", 32'(overrun), 32'd0);
    chk("t1_dropped", 32'(frames_dropped), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    x0 = xfers;
    for (int i = 0; i < 7; i++) cyc(1, 1, 16'($urandom), 1);
    repeat (4) cyc(1, 0, 16'h0, 1);
    chk("t1_no_early_frame", 32'(out_valid), 32'd0);
    chk("t1_no_xfer", 32'(xfers - x0), 32'd0);
    cyc(1, 1, 16'($urandom), 1);
    repeat (14) cyc(1, 0, 16'h0, 1);
    chk("t1_drained", 32'(exp_q.size()), 32'd0);

    // Ready toggling every cycle.
    flush();
    x0 = xfers; l0 = lasts;
    for (int i = 0; i < 8; i++) cyc(1, 1, 16'($urandom), 0);
    for (int i = 0; i < 30; i++) cyc(1, 0, 16'h0, (i % 2) == 1);
    chk("t5_xfers", 32'(xfers - x0), 32'd8);
    chk("t5_lasts", 32'(lasts - l0), 32'd1);
    chk("t5_drained", 32'(exp_q.size()), 32'd0);

    // Enable dropped mid-frame.
    flush();
    for (int i = 0; i < 8; i++) cyc(1, 1, 16'($urandom), 1);
    x0 = xfers;
    for (int c = 0; c < 20 && xfers - x0 < 3; c++) cyc(1, 0, 16'h0, 1);
    l0 = lasts;
    cyc(0, 0, 16'h0, 0);
    model_reset();
    cyc(1, 0, 16'h0, 1);
    chk("t6_valid_low", 32'(out_valid), 32'd0);
    chk("t6_last_low", 32'(out_last), 32'd0);
    chk("t6_no_last", 32'(lasts - l0), 32'd0);
    first_x = 16'($urandom);
    cyc(1, 1, first_x, 1);
    for (int i = 0; i < 6; i++) cyc(1, 1, 16'($urandom), 1);
    repeat (3) cyc(1, 0, 16'h0, 1);
    chk("t6_no_early_frame", 32'(out_valid), 32'd0);
    cyc(1, 1, 16'($urandom), 1);
    repeat (14) cyc(1, 0, 16'h0, 1);
    chk("t6_drained", 32'(exp_q.size()), 32'd0);
    chk("t6_first_y", 32'(got[0]), 32'(first_x));

    // Randomized data and ready.
    flush();
    l0 = lasts;
    for (int i = 0; i < 320; i++) cyc(1, (i % 8) == 0, 16'($urandom), ($urandom % 2) == 1);
    repeat (30) cyc(1, 0, 16'h0, 1);
    chk("rand_drained", 32'(exp_q.size()), 32'd0);
    chk("rand_frames", 32'(lasts - l0), 32'd9);
    chk("rand_dropped", 32'(frames_dropped), 32'd0);
    chk("rand_overrun", 32'(overrun), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
